// File: rtl/nios2_key_ctrl_pkg.sv
// nios2_key_ctrl_pkg: register map and reset constants shared by the key controller
package nios2_key_ctrl_pkg;
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_RSVD = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;
    localparam logic KEY_RESET = 1'b1;
endpackage

// File: rtl/nios2_key_debounce.sv
// nios2_key_debounce: 2-flop synchronizer and hold-time debouncer for one active-low key
module nios2_key_debounce
    import nios2_key_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key,
    output logic sync_level,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic meta;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= KEY_RESET;
            sync_level <= KEY_RESET;
            level <= KEY_RESET;
            cnt <= '0;
        end else begin
            meta <= key;
            sync_level <= meta;
            cnt <= (sync_level == level || cnt == CNT_MAX) ? '0 : cnt + CW'(1);
            if (sync_level != level && cnt == CNT_MAX) level <= sync_level;
        end
    end
endmodule

// File: rtl/nios2_key_ctrl.sv
// nios2_key_ctrl: Avalon-MM debounced key port with edge capture and level irq
// NIOS2_KEY_CTRL_RELEASE_EDGE_EN adds release edge bits [2*KEY_WIDTH-1:KEY_WIDTH].
module nios2_key_ctrl
    import nios2_key_ctrl_pkg::*;
#(
    parameter int KEY_WIDTH = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 chipselect,
    input  logic [1:0]           address,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [KEY_WIDTH-1:0] in_port,
    output logic                 irq
);
`ifdef NIOS2_KEY_CTRL_RELEASE_EDGE_EN
    localparam int EW = 2 * KEY_WIDTH;
`else
    localparam int EW = KEY_WIDTH;
`endif
    logic [KEY_WIDTH-1:0] sync_level, level, level_q, armed, press;
    logic [EW-1:0] edge_set, edge_clr, edge_reg, irq_mask;
    logic [1:0] boot;
    logic wr;
    genvar i;
    generate
        for (i = 0; i < KEY_WIDTH; i++) begin : g_key
            nios2_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .clk(clk),
                .reset_n(reset_n),
                .key(in_port[i]),
                .sync_level(sync_level[i]),
                .level(level[i])
            );
        end
    endgenerate
    // A key only arms once it has been seen released, so keys held through reset never report a press.
    always_comb begin
        wr = chipselect && !write_n;
        press = level_q & ~level & armed;
`ifdef NIOS2_KEY_CTRL_RELEASE_EDGE_EN
        edge_set = {~level_q & level, press};
`else
        edge_set = press;
`endif
        edge_clr = (wr && address == ADDR_EDGE) ? writedata[EW-1:0] : '0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= {KEY_WIDTH{KEY_RESET}};
            armed <= '0;
            boot <= '0;
            edge_reg <= '0;
            irq_mask <= '0;
            readdata <= '0;
            irq <= 1'b0;
        end else begin
            level_q <= level;
            boot <= {boot[0], 1'b1};
            armed <= armed | (sync_level & {KEY_WIDTH{boot[1]}});
            edge_reg <= (edge_reg & ~edge_clr) | edge_set;
            if (wr && address == ADDR_MASK) irq_mask <= writedata[EW-1:0];
            irq <= |(edge_reg & irq_mask);
            readdata <= address == ADDR_DATA ? 32'(level) :
                        address == ADDR_MASK ? 32'(irq_mask) :
                        address == ADDR_EDGE ? 32'(edge_reg) : '0;
        end
    end
endmodule

// File: doc/nios2_key_ctrl.md
NIOS2_KEY_CTRL -- requirements
Module: nios2_key_ctrl

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 4, number of key inputs (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, clk cycles a new key level must hold before acceptance (≥2).
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-006 SHALL have port address  input  2  word address.
REQ-007 SHALL have port write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port readdata  output  32  registered read data.
REQ-010 SHALL have port in_port  input  KEY_WIDTH  raw asynchronous keys, active-low (0 = pressed).
REQ-011 SHALL have port irq  output  1  level interrupt, active-high.

Function
REQ-012 SHALL pass each in_port bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL keep, per key, a debounced level, reset 1, and a counter of width $clog2(DEBOUNCE_CYCLES).
REQ-014 SHALL clear the counter in any cycle where the synchronized level equals the debounced level.
REQ-015 SHALL increment the counter in any cycle where the levels differ and the counter is below DEBOUNCE_CYCLES-1.
REQ-016 SHALL, when the levels differ and the counter equals DEBOUNCE_CYCLES-1, copy the synchronized level into the debounced level and clear the counter, with no wrap past DEBOUNCE_CYCLES-1.
REQ-017 SHALL restart the count from 0 on any glitch shorter than DEBOUNCE_CYCLES; such glitches never change the debounced level.
REQ-018 SHALL set edge bit i in the cycle after debounced level i goes 1->0 (press).
REQ-019 SHALL map registers as: 0 = DATA (RO, debounced levels in bits [KEY_WIDTH-1:0]); 1 = IRQ_MASK (RW, bits [KEY_WIDTH-1:0]); 2 = reserved (reads 0, writes ignored); 3 = EDGE (RO, write-1-to-clear).
REQ-020 SHALL update readdata on every clock edge to the addressed register, zero-extended, so read latency is 1 cycle and unused bits read 0.
REQ-021 SHALL let a write take effect on the clock edge where chipselect=1 and write_n=0.
REQ-022 SHALL give the set priority when an EDGE bit receives a set and a write-1-clear in the same cycle, leaving the bit 1.
REQ-023 SHALL drive irq as the registered OR of (EDGE & IRQ_MASK), updating 1 cycle after either input changes.

Reset
REQ-024 SHALL, on reset_n low, immediately force: synchronizers and debounced levels to all 1, counters 0, EDGE 0, IRQ_MASK 0, readdata 0, irq 0.
REQ-025 SHALL abandon any in-progress debounce when reset asserts mid-count, and SHALL generate no edge when a key is already held at reset release until it releases and presses again.

Configuration
REQ-026 SHALL, with NIOS2_KEY_CTRL_RELEASE_EDGE_EN defined, also set EDGE bit KEY_WIDTH+i on debounced 0->1 (release) of key i, widen IRQ_MASK to 2*KEY_WIDTH bits, and apply REQ-022/REQ-023 to these bits.
REQ-027 SHALL, without NIOS2_KEY_CTRL_RELEASE_EDGE_EN, implement only press bits, with bits ≥KEY_WIDTH of EDGE and IRQ_MASK reading 0.

Structure
REQ-028 SHALL place register address constants (ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=3) and the debounced-level reset value in package nios2_key_ctrl_pkg.
REQ-029 SHALL implement the synchronizer, counter and debounced level for one key as sub-module nios2_key_debounce, instantiated KEY_WIDTH times via generate.

Verification
All scenarios use DEBOUNCE_CYCLES=8 and KEY_WIDTH=4.
REQ-030 SHALL cover: reset, then read addr 0 -> readdata=0x0000000F one cycle later; irq=0.
REQ-031 SHALL cover: in_port[0] held low 20 cycles -> DATA=0xE after 2+8 cycles; EDGE=0x1; irq=1 only after IRQ_MASK=0x1 is written.
REQ-032 SHALL cover: in_port[1] low pulses of 7 cycles, repeated -> DATA stays 0xF; EDGE stays 0.
REQ-033 SHALL cover: EDGE=0x1; write 0x1 to addr 3 -> EDGE=0, irq=0 next cycle; a press set in the same cycle as the clear -> EDGE bit stays 1.
REQ-034 SHALL cover: key 2 held from reset release -> no EDGE; release then press -> EDGE=0x4; with NIOS2_KEY_CTRL_RELEASE_EDGE_EN the release also sets EDGE bit 6 (0x40).
REQ-035 SHALL cover: reset_n pulsed low while key 3 is mid-count -> counters 0, DATA=0xF, no edge recorded.
